top_mod: RTL and testbench
==========================

// Module: top_mod
// PURPOSE
//  GPS front end: takes received NMEA bytes (byte + valid strobe from the UART RX),
//  parses $GPGGA sentences and extracts time, latitude and longitude.
//  Sends the extracted record out again on a built-in 8N1 UART transmitter.
//  Top of the GPS datapath; drives the board TX pin.
// PARAMETERS
//  CLKS_PER_BIT  16  clocks per UART bit (868 = 115200 baud @ 100 MHz in hardware)
//  MAX_FIELD     12  maximum characters stored for the time, lat and lon fields
// PORTS
//  clk          in   1  system clock, rising edge
//  rst          in   1  reset, asynchronous, active-low
//  uart_data    in   8  received ASCII byte
//  uart_valid   in   1  byte strobe; one byte accepted per high clock
//  o_Tx_Serial  out  1  UART TX line, idle high
// BEHAVIOUR
//  - Reset (rst=0), asynchronous:
//    - o_Tx_Serial=1; parser and TX FSMs return to IDLE.
//    - Field buffers and the TX buffer are cleared.
//  - Parser FSM advances only on cycles with uart_valid=1.
//  - Parser states: IDLE, HDR, TIME, LAT, LAT_DIR, LON, LON_DIR.
//    - '$' seen in ANY state: clear field buffers, go to HDR (restart).
//    - IDLE: wait for '$'; all other bytes are ignored.
//    - HDR: collect header bytes until ','.
//      - Header is exactly "GPGGA" -> TIME.
//      - Any other header -> IDLE.
//    - TIME, LAT, LON: store '0'-'9' and '.'.
//      - ',' ends the field: TIME->LAT, LAT->LAT_DIR, LON->LON_DIR.
//      - Abort to IDLE on: any other byte, an empty field at ',',
//        or more than MAX_FIELD characters.
//    - LAT_DIR: expects 'N' or 'S', then ','; then go to LON.
//      Abort to IDLE on any other sequence.
//    - LON_DIR: 'E' or 'W' completes the record; parser -> IDLE.
//      Any other byte -> IDLE. No checksum or CR/LF is required to complete.
//  - Record output:
//    - Format: <time>,<lat>,<N|S>,<lon>,<E|W>,CR,LF.
//    - Built in a 40-byte TX buffer on the clock the E/W byte is accepted.
//    - The start bit begins on the following clock.
//  - TX FSM states: IDLE, START, DATA, STOP, NEXT.
//    - Frame is 8N1, LSB first.
//    - Every bit is held CLKS_PER_BIT clocks.
//    - Bytes go out back-to-back with no idle gap until LF has been sent.
//    - TX then returns to IDLE with the line high.
//  - A record that completes while TX is busy is dropped; the frame in flight is
//    unaffected. Parsing continues normally while TX runs.
//  - Reset mid-frame: line goes high at once; no partial byte resumes after reset.
//  - Field lengths vary (1..MAX_FIELD); the output length follows the actual lengths.
// TESTING
//  - Send "$GPGGA,123519,3130,N,12024,E", 1 byte per 20 ns.
//    -> TX emits the 23 bytes "123519,3130,N,12024,E\r\n",
//       each 10*CLKS_PER_BIT clocks, LSB first.
//  - Send "$GPRMC,123519,..." -> o_Tx_Serial stays 1 throughout.
//  - Send "$GPGGA,12" then "$GPGGA,000001,1,S,2,W"
//    -> output is "000001,1,S,2,W\r\n" only.
//  - Send an invalid lat direction ('X') -> no output; a following valid sentence
//    is still parsed and transmitted.
//  - Assert rst mid-transmission -> line immediately 1, no further frames;
//    a new sentence after release transmits normally.
//  - Send a second full sentence while the first is transmitting
//    -> only the first record appears; the second is dropped.

Source files
------------

// File: rtl/top_mod.sv
// GPS $GPGGA parser that re-emits time/lat/lon as an ASCII record on an 8N1 UART TX line.
// Latency: start bit begins the clock after the E/W byte is accepted.
// Backpressure: none on input; a record completing while TX is busy is dropped.
module top_mod #(
  parameter int CLKS_PER_BIT = 16,
  parameter int MAX_FIELD    = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] uart_data,
  input  logic       uart_valid,
  output logic       o_Tx_Serial
);

  localparam int TX_DEPTH = 40;
  localparam int PTR_W    = $clog2(TX_DEPTH);
  localparam int POS_W    = PTR_W + 1;
  localparam int LEN_W    = $clog2(MAX_FIELD + 1);
  localparam int IDX_W    = (MAX_FIELD > 1) ? $clog2(MAX_FIELD) : 1;
  localparam int CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT - 2);

  localparam logic [7:0] C_DOLLAR = 8'h24;
  localparam logic [7:0] C_COMMA  = 8'h2C;
  localparam logic [7:0] C_CR     = 8'h0D;
  localparam logic [7:0] C_LF     = 8'h0A;

  typedef enum logic [2:0] {
    P_IDLE, P_HDR, P_TIME, P_LAT, P_LAT_DIR, P_LON, P_LON_DIR
  } p_state_t;

  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA, T_STOP, T_NEXT
  } t_state_t;

  p_state_t p_state, p_nxt;
  logic [2:0]       hdr_cnt;
  logic             hdr_ok;
  logic [7:0]       time_buf [MAX_FIELD];
  logic [7:0]       lat_buf  [MAX_FIELD];
  logic [7:0]       lon_buf  [MAX_FIELD];
  logic [LEN_W-1:0] time_len, lat_len, lon_len, cur_len;
  logic [7:0]       lat_dir;
  logic             dir_seen;

  logic clr, hdr_push, fld_wr, dir_wr, rec_done;
  logic is_comma, is_fchar, is_ns, is_ew;

  function automatic logic [7:0] hdr_char(input logic [2:0] i);
    case (i)
      3'd0:    return 8'h47;  // G
      3'd1:    return 8'h50;  // P
      3'd2:    return 8'h47;  // G
      3'd3:    return 8'h47;  // G
      3'd4:    return 8'h41;  // A
      default: return 8'h00;
    endcase
  endfunction

  assign is_comma = (uart_data == C_COMMA);
  assign is_fchar = ((uart_data >= 8'h30) && (uart_data <= 8'h39)) || (uart_data == 8'h2E);
  assign is_ns    = (uart_data == 8'h4E) || (uart_data == 8'h53);
  assign is_ew    = (uart_data == 8'h45) || (uart_data == 8'h57);

  always_comb begin
    case (p_state)
      P_LAT:   cur_len = lat_len;
      P_LON:   cur_len = lon_len;
      default: cur_len = time_len;
    endcase
  end

  always_comb begin
    p_nxt    = p_state;
    clr      = 1'b0;
    hdr_push = 1'b0;
    fld_wr   = 1'b0;
    dir_wr   = 1'b0;
    rec_done = 1'b0;
    if (uart_valid) begin
      if (uart_data == C_DOLLAR) begin
        p_nxt = P_HDR;
        clr   = 1'b1;
      end else begin
        case (p_state)
          P_IDLE: p_nxt = P_IDLE;
          P_HDR: begin
            if (is_comma) begin
              if (hdr_cnt == 3'd5 && hdr_ok) p_nxt = P_TIME;
              else                           p_nxt = P_IDLE;
            end else begin
              hdr_push = 1'b1;
            end
          end
          P_TIME, P_LAT, P_LON: begin
            if (is_fchar) begin
              if (cur_len == LEN_W'(MAX_FIELD)) p_nxt = P_IDLE;
              else                              fld_wr = 1'b1;
            end else if (is_comma && cur_len != '0) begin
              if (p_state == P_TIME)     p_nxt = P_LAT;
              else if (p_state == P_LAT) p_nxt = P_LAT_DIR;
              else                       p_nxt = P_LON_DIR;
            end else begin
              p_nxt = P_IDLE;
            end
          end
          P_LAT_DIR: begin
            if (!dir_seen && is_ns)         dir_wr = 1'b1;
            else if (dir_seen && is_comma)  p_nxt  = P_LON;
            else                            p_nxt  = P_IDLE;
          end
          P_LON_DIR: begin
            p_nxt    = P_IDLE;
            rec_done = is_ew;
          end
          default: p_nxt = P_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_state  <= P_IDLE;
      hdr_cnt  <= '0;
      hdr_ok   <= 1'b0;
      time_buf <= '{default: '0};
      lat_buf  <= '{default: '0};
      lon_buf  <= '{default: '0};
      time_len <= '0;
      lat_len  <= '0;
      lon_len  <= '0;
      lat_dir  <= '0;
      dir_seen <= 1'b0;
    end else begin
      p_state <= p_nxt;
      if (clr) begin
        hdr_cnt  <= '0;
        hdr_ok   <= 1'b1;
        time_buf <= '{default: '0};
        lat_buf  <= '{default: '0};
        lon_buf  <= '{default: '0};
        time_len <= '0;
        lat_len  <= '0;
        lon_len  <= '0;
        lat_dir  <= '0;
        dir_seen <= 1'b0;
      end
      if (hdr_push) begin
        // Any mismatch or a sixth header character disqualifies the sentence.
        if (hdr_cnt >= 3'd5 || uart_data != hdr_char(hdr_cnt)) hdr_ok <= 1'b0;
        if (hdr_cnt != 3'd7) hdr_cnt <= hdr_cnt + 3'd1;
      end
      if (fld_wr) begin
        case (p_state)
          P_TIME: begin
            time_buf[time_len[IDX_W-1:0]] <= uart_data;
            time_len <= time_len + 1'b1;
          end
          P_LAT: begin
            lat_buf[lat_len[IDX_W-1:0]] <= uart_data;
            lat_len <= lat_len + 1'b1;
          end
          P_LON: begin
            lon_buf[lon_len[IDX_W-1:0]] <= uart_data;
            lon_len <= lon_len + 1'b1;
          end
          default: ;
        endcase
      end
      if (dir_wr) begin
        lat_dir  <= uart_data;
        dir_seen <= 1'b1;
      end
    end
  end

  // Record assembly; the E/W byte comes straight from the input this cycle.
  logic [7:0]       rec [TX_DEPTH];
  logic [POS_W-1:0] pos;

  always_comb begin
    rec = '{default: '0};
    pos = '0;
    for (int k = 0; k < MAX_FIELD; k++) begin
      if (LEN_W'(k) < time_len) begin
        if (pos < POS_W'(TX_DEPTH)) rec[pos[PTR_W-1:0]] = time_buf[IDX_W'(k)];
        pos = pos + 1'b1;
      end
    end
    if (pos < POS_W'(TX_DEPTH)) rec[pos[PTR_W-1:0]] = C_COMMA;
    pos = pos + 1'b1;
    for (int k = 0; k < MAX_FIELD; k++) begin
      if (LEN_W'(k) < lat_len) begin
        if (pos < POS_W'(TX_DEPTH)) rec[pos[PTR_W-1:0]] = lat_buf[IDX_W'(k)];
        pos = pos + 1'b1;
      end
    end
    if (pos < POS_W'(TX_DEPTH)) rec[pos[PTR_W-1:0]] = C_COMMA;
    pos = pos + 1'b1;
    if (pos < POS_W'(TX_DEPTH)) rec[pos[PTR_W-1:0]] = lat_dir;
    pos = pos + 1'b1;
    if (pos < POS_W'(TX_DEPTH)) rec[pos[PTR_W-1:0]] = C_COMMA;
    pos = pos + 1'b1;
    for (int k = 0; k < MAX_FIELD; k++) begin
      if (LEN_W'(k) < lon_len) begin
        if (pos < POS_W'(TX_DEPTH)) rec[pos[PTR_W-1:0]] = lon_buf[IDX_W'(k)];
        pos = pos + 1'b1;
      end
    end
    if (pos < POS_W'(TX_DEPTH)) rec[pos[PTR_W-1:0]] = C_COMMA;
    pos = pos + 1'b1;
    if (pos < POS_W'(TX_DEPTH)) rec[pos[PTR_W-1:0]] = uart_data;
    pos = pos + 1'b1;
    if (pos < POS_W'(TX_DEPTH)) rec[pos[PTR_W-1:0]] = C_CR;
    pos = pos + 1'b1;
    if (pos < POS_W'(TX_DEPTH)) rec[pos[PTR_W-1:0]] = C_LF;
    pos = pos + 1'b1;
  end

  t_state_t t_state, t_nxt;
  logic [7:0]       tx_buf [TX_DEPTH];
  logic [PTR_W-1:0] tx_len, byte_idx, byte_nxt;
  logic [CNT_W-1:0] clk_cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_nxt;
  logic             load, line_nxt;

  // Records that would not fit the TX buffer are discarded like busy-time records.
  assign load = rec_done && (t_state == T_IDLE) && (pos <= POS_W'(TX_DEPTH));

  always_comb begin
    t_nxt    = t_state;
    cnt_nxt  = clk_cnt;
    bit_nxt  = bit_idx;
    byte_nxt = byte_idx;
    case (t_state)
      T_IDLE: begin
        if (load) begin
          t_nxt    = T_START;
          cnt_nxt  = '0;
          byte_nxt = '0;
        end
      end
      T_START: begin
        if (clk_cnt == BIT_LAST) begin
          t_nxt   = T_DATA;
          cnt_nxt = '0;
          bit_nxt = '0;
        end else begin
          cnt_nxt = clk_cnt + 1'b1;
        end
      end
      T_DATA: begin
        if (clk_cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (bit_idx == 3'd7) t_nxt   = T_STOP;
          else                 bit_nxt = bit_idx + 3'd1;
        end else begin
          cnt_nxt = clk_cnt + 1'b1;
        end
      end
      // STOP plus the single NEXT clock make up one full stop bit.
      T_STOP: begin
        if (clk_cnt == STOP_LAST) begin
          t_nxt   = T_NEXT;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = clk_cnt + 1'b1;
        end
      end
      T_NEXT: begin
        if (byte_idx == tx_len - 1'b1) begin
          t_nxt = T_IDLE;
        end else begin
          t_nxt    = T_START;
          byte_nxt = byte_idx + 1'b1;
        end
      end
      default: t_nxt = T_IDLE;
    endcase

    case (t_nxt)
      T_START: line_nxt = 1'b0;
      T_DATA:  line_nxt = tx_buf[byte_nxt][bit_nxt];
      default: line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_state     <= T_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      tx_len      <= '0;
      tx_buf      <= '{default: '0};
      o_Tx_Serial <= 1'b1;
    end else begin
      t_state     <= t_nxt;
      clk_cnt     <= cnt_nxt;
      bit_idx     <= bit_nxt;
      byte_idx    <= byte_nxt;
      o_Tx_Serial <= line_nxt;
      if (load) begin
        tx_buf <= rec;
        tx_len <= pos[PTR_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_top_mod.sv
// Bench for top_mod: drives NMEA sentences, decodes the TX line and scores records.
module tb_top_mod;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] uart_data = 8'h00;
  logic       uart_valid = 1'b0;
  logic       o_Tx_Serial;

  top_mod #(.CLKS_PER_BIT(CPB), .MAX_FIELD(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_data   (uart_data),
    .uart_valid  (uart_valid),
    .o_Tx_Serial (o_Tx_Serial)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q [$];
  logic [7:0] rx_q  [$];
  int         rx_t  [$];
  int low_cnt    = 0;
  int frame_err  = 0;
  int model_busy = 0;

  // Line receiver: samples mid-bit on falling clock edges, abandons a frame on reset.
  bit         mon_busy;
  int         mon_cnt, mon_k, mon_start;
  logic [7:0] mon_sh;
  initial begin
    mon_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (o_Tx_Serial !== 1'b1) low_cnt++;
      if (rst !== 1'b1) begin
        mon_busy = 1'b0;
      end else if (!mon_busy) begin
        if (o_Tx_Serial === 1'b0) begin
          mon_busy  = 1'b1;
          mon_cnt   = 0;
          mon_start = cyc;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt % CPB == CPB / 2) begin
          mon_k = mon_cnt / CPB;
          if (mon_k == 0) begin
            if (o_Tx_Serial !== 1'b0) begin
              frame_err++;
              mon_busy = 1'b0;
            end
          end else if (mon_k <= 8) begin
            mon_sh[mon_k-1] = o_Tx_Serial;
          end else begin
            if (o_Tx_Serial !== 1'b1) frame_err++;
            rx_q.push_back(mon_sh);
            rx_t.push_back(mon_start);
            mon_busy = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    uart_data  = b;
    uart_valid = 1'b1;
    @(negedge clk);
    uart_valid = 1'b0;
    uart_data  = 8'h00;
  endtask

  // Pushes the expected record only if the modelled transmitter is idle.
  task automatic send_sentence(input string s, input string rec);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    if (rec.len() > 0 && cyc > model_busy) begin
      for (int i = 0; i < rec.len(); i++) exp_q.push_back(rec[i]);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      model_busy = cyc + (rec.len() + 2) * FRAME;
    end
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge clk);
    ok = (rx_q.size() >= n);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    settle(3);
    tests++;
    if (o_Tx_Serial !== 1'b1) begin
      fails++;
      $display("FAIL reset_line: got %b expected 1", o_Tx_Serial);
    end
    rst = 1'b1;
    settle(20);
    tests++;
    if (low_cnt != 0) begin
      fails++;
      $display("FAIL idle_after_reset: low samples %0d expected 0", low_cnt);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int bad, n;
    logic [7:0] a, e;
    send_sentence("$GPGGA,123519,3130,N,12024,E", "123519,3130,N,12024,E");
    tests++;
    if (o_Tx_Serial !== 1'b0) begin
      fails++;
      $display("FAIL basic_start_next_clock: line %b expected 0", o_Tx_Serial);
    end
    n = exp_q.size();
    wait_rx(n, n * FRAME + 100, ok);
    tests++;
    if (!ok || n != 23) begin
      fails++;
      $display("FAIL basic_count: got %0d bytes expected 23 (queued %0d)", rx_q.size(), n);
    end
    bad = 0;
    for (int i = 1; i < rx_t.size(); i++) if (rx_t[i] - rx_t[i-1] != FRAME) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL basic_byte_spacing: %0d gaps differ from %0d clocks", bad, FRAME);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL basic_byte: got %h expected %h", a, e);
      end
    end
    settle(2 * FRAME);
    tests++;
    if (rx_q.size() != 0 || o_Tx_Serial !== 1'b1) begin
      fails++;
      $display("FAIL basic_tail: extra %0d bytes, line %b expected 0 bytes, line 1", rx_q.size(), o_Tx_Serial);
    end
    rx_t.delete();
  endtask

  task automatic test_wrong_header();
    int snap;
    snap = low_cnt;
    send_sentence("$GPRMC,123519,3130,N,12024,E", "");
    send_sentence("$GPGGAX,123519,3130,N,12024,E", "");
    settle(3 * FRAME);
    tests++;
    if (low_cnt != snap || rx_q.size() != 0) begin
      fails++;
      $display("FAIL wrong_header_quiet: low samples %0d bytes %0d expected 0 and 0", low_cnt - snap, rx_q.size());
    end
  endtask

  task automatic test_restart();
    bit ok;
    logic [7:0] a, e;
    send_sentence("$GPGGA,12", "");
    send_sentence("$GPGGA,000001,1,S,2,W", "000001,1,S,2,W");
    wait_rx(exp_q.size(), exp_q.size() * FRAME + 100, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL restart_count: got %0d bytes expected %0d", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL restart_byte: got %h expected %h", a, e);
      end
    end
    settle(2 * FRAME);
    tests++;
    if (rx_q.size() != 0) begin
      fails++;
      $display("FAIL restart_extra: got %0d extra bytes expected 0", rx_q.size());
    end
    rx_t.delete();
  endtask

  task automatic test_bad_dir();
    bit ok;
    int snap;
    logic [7:0] a, e;
    snap = low_cnt;
    send_sentence("$GPGGA,123519,3130,X,12024,E", "");
    settle(FRAME);
    tests++;
    if (low_cnt != snap) begin
      fails++;
      $display("FAIL bad_dir_quiet: low samples %0d expected 0", low_cnt - snap);
    end
    send_sentence("$GPGGA,1,2,N,3,E", "1,2,N,3,E");
    wait_rx(exp_q.size(), exp_q.size() * FRAME + 100, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL bad_dir_recover_count: got %0d bytes expected %0d", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL bad_dir_recover_byte: got %h expected %h", a, e);
      end
    end
    settle(2 * FRAME);
    rx_t.delete();
  endtask

  task automatic test_field_limits();
    bit ok;
    int snap;
    logic [7:0] a, e;
    send_sentence("$GPGGA,123456.89012,1,N,2,E", "123456.89012,1,N,2,E");
    wait_rx(exp_q.size(), exp_q.size() * FRAME + 100, ok);
    tests++;
    if (!ok || rx_q.size() != 22) begin
      fails++;
      $display("FAIL max_field_count: got %0d bytes expected 22", rx_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL max_field_byte: got %h expected %h", a, e);
      end
    end
    settle(2 * FRAME);
    snap = low_cnt;
    send_sentence("$GPGGA,1234567890123,1,N,2,E", "");
    send_sentence("$GPGGA,,1,N,2,E", "");
    send_sentence("$GPGGA,12a4,1,N,2,E", "");
    settle(2 * FRAME);
    tests++;
    if (low_cnt != snap || rx_q.size() != 0) begin
      fails++;
      $display("FAIL field_abort_quiet: low samples %0d bytes %0d expected 0 and 0", low_cnt - snap, rx_q.size());
    end
    rx_t.delete();
  endtask

  task automatic test_busy_drop();
    bit ok;
    logic [7:0] a, e;
    send_sentence("$GPGGA,111111,22,N,33,E", "111111,22,N,33,E");
    send_sentence("$GPGGA,999999,88,S,77,W", "999999,88,S,77,W");
    wait_rx(exp_q.size(), exp_q.size() * FRAME + 100, ok);
    tests++;
    if (!ok || exp_q.size() != 18) begin
      fails++;
      $display("FAIL busy_count: got %0d bytes, queued %0d expected 18", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL busy_byte: got %h expected %h", a, e);
      end
    end
    settle(3 * FRAME);
    tests++;
    if (rx_q.size() != 0) begin
      fails++;
      $display("FAIL busy_second_dropped: got %0d extra bytes expected 0", rx_q.size());
    end
    rx_t.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int snap;
    logic [7:0] a, e;
    send_sentence("$GPGGA,123519,3130,N,12024,E", "123519,3130,N,12024,E");
    wait_rx(2, 2 * FRAME + 100, ok);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL reset_mid_prefix: got %h expected %h", a, e);
      end
    end
    for (int i = 0; i < FRAME && o_Tx_Serial !== 1'b0; i++) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    tests++;
    if (o_Tx_Serial !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_line: got %b expected 1", o_Tx_Serial);
    end
    settle(4);
    rst = 1'b1;
    snap = low_cnt;
    settle(3 * FRAME);
    tests++;
    if (low_cnt != snap || rx_q.size() != 0) begin
      fails++;
      $display("FAIL reset_mid_quiet: low samples %0d bytes %0d expected 0 and 0", low_cnt - snap, rx_q.size());
    end
    exp_q.delete();
    rx_q.delete();
    rx_t.delete();
    model_busy = 0;
    send_sentence("$GPGGA,000002,5,N,6,E", "000002,5,N,6,E");
    wait_rx(exp_q.size(), exp_q.size() * FRAME + 100, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL reset_mid_after_count: got %0d bytes expected %0d", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL reset_mid_after_byte: got %h expected %h", a, e);
      end
    end
    settle(2 * FRAME);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrong_header();
    test_restart();
    test_bad_dir();
    test_field_limits();
    test_busy_drop();
    test_reset_mid();
    tests++;
    if (frame_err != 0) begin
      fails++;
      $display("FAIL framing: %0d bad start/stop samples expected 0", frame_err);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
